act_lut_writer: RTL and testbench
=================================

# act_lut_writer

Writable breakpoint table for the LSTM activation-function path. It accepts a stream of 17 signed 8-bit breakpoints over a valid/ready handshake and stores them in a register file. It serves the same `address → base / next__data` read interface that the interpolator consumes, so sigmoid/tanh curves can be reloaded at run time instead of being fixed in the netlist.

## Interface
- `DATA_W`, 8: breakpoint width, signed.
- `ADDR_W`, 4: segment address width; the table holds 2^ADDR_W+1 = 17 entries.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `load_start`  in  1: begin a load session; single-cycle pulse.
- `wr_valid`  in  1: `wr_data` holds a breakpoint.
- `wr_ready`  out  1: table accepts a breakpoint this cycle.
- `wr_data`  in  DATA_W signed: breakpoint value, written in ascending index order 0..16.
- `busy`  out  1: session in progress (state LOAD or DONE).
- `load_done`  out  1: one-cycle pulse at session completion.
- `table_valid`  out  1: table fully loaded and accepted.
- `restart_err`  out  1: one-cycle pulse when `load_start` arrives during LOAD.
- `address`  in  ADDR_W: segment index (upper bits of `z__value`).
- `base`  out  DATA_W signed: entry[address].
- `next__data`  out  DATA_W signed: entry[address+1].

## Operation
- FSM states: IDLE, LOAD, DONE.
- **IDLE:** `wr_ready`=0.
  - `load_start`=1 → LOAD. Clear the index to 0 and clear `table_valid`.
- **LOAD:** `wr_ready`=1.
  - When `wr_valid & wr_ready`, write entry[index] ← `wr_data` and increment index (5-bit).
  - Accepting index 16 → DONE.
  - `wr_valid`=0 cycles stall without limit; there is no timeout.
- **DONE:** lasts exactly one cycle.
  - `load_done`=1 and `wr_ready`=0.
  - `table_valid`←1 on exit, subject to the Configuration section.
  - Next state is IDLE.
- **Restart:** `load_start` in LOAD resets index to 0, pulses `restart_err`, and stays in LOAD.
  - Any beat presented in that same cycle is not written; `wr_ready` is forced 0 for that cycle.
  - `load_start` in DONE is ignored.
- **Read port:** purely combinational from the register file.
  - The `address+1` computation is ADDR_W+1 bits wide with no wrap, so address 15 returns entries 15 and 16.
  - Reads during LOAD return the current mixture of old and new entries; consumers must gate on `table_valid`.
- **Reset:**
  - All entries become 0 and the index becomes 0.
  - State → IDLE.
  - All outputs go to 0: `wr_ready`, `busy`, `load_done`, `table_valid`, `restart_err`.
  - With entries at 0, `base` and `next__data` also read 0.
  - Reset mid-load discards the partial table.

## Timing
- A write takes effect on the accepting clock edge; the read port shows the new value in the following cycle.
- Minimum session length from `load_start` to `load_done` (no stalls): 1 cycle to enter LOAD, 17 beat cycles, then DONE.
  - `load_done` is high in cycle 18 after the `load_start` cycle.
  - `table_valid` rises in cycle 19.
- `wr_ready` is a registered function of state only, except for the restart-cycle mask. It never depends combinationally on `wr_valid`.
- `busy` is high in LOAD and DONE.

## Configuration
- **`ACT_LUT_MONOTONIC_CHECK_EN`:**
  - **When defined:** each accepted beat with index > 0 is compared as a signed value against the previously accepted beat.
    - Any `wr_data` < previous sets a sticky violation flag, which clears on `load_start`.
    - At DONE with the flag set: `load_done` still pulses but `table_valid` stays 0, and an extra output `mono_err` (1 bit, reset 0) is 1 from DONE until the next `load_start` or reset.
  - **When undefined:** no comparator, no `mono_err` port, and DONE always sets `table_valid`.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles → all outputs 0; `base`=`next__data`=0 for every address.
- **Full load, no stalls:** load_start, then 17 beats with values −64 + 8·i → `load_done` at cycle 18, `table_valid`=1 at cycle 19.
  - `address`=3 → `base`=−40, `next__data`=−32.
  - `address`=15 → `base`=56, `next__data`=64.
- **Backpressure:** same data with `wr_valid` deasserted every other cycle → identical table; `load_done` at cycle 34.
- **Restart:** after 5 beats, assert `load_start` together with a beat → `restart_err` pulse and that beat is not written. Then 17 beats of value 7 → every entry = 7 and `table_valid`=1.
- **Reset mid-load:** reset after 10 beats → state IDLE, all entries 0, `table_valid`=0, `wr_ready`=0 the next cycle.
- **With `ACT_LUT_MONOTONIC_CHECK_EN`:** a ramp with beat 9 = −100 → `load_done` pulses, `table_valid`=0, `mono_err`=1. The next clean ramp clears `mono_err` and sets `table_valid`.

Source files
------------

// File: rtl/act_lut_writer_if.sv
// act_lut_writer_if: load handshake, status and read-port bundle for act_lut_writer; mono_err exists only with ACT_LUT_MONOTONIC_CHECK_EN
interface act_lut_writer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic                     load_start;
    logic                     wr_valid;
    logic                     wr_ready;
    logic signed [DATA_W-1:0] wr_data;
    logic                     busy;
    logic                     load_done;
    logic                     table_valid;
    logic                     restart_err;
    logic        [ADDR_W-1:0] address;
    logic signed [DATA_W-1:0] base;
    logic signed [DATA_W-1:0] next__data;
`ifdef ACT_LUT_MONOTONIC_CHECK_EN
    logic                     mono_err;
`endif

    modport master (
        output load_start, wr_valid, wr_data, address,
        input
`ifdef ACT_LUT_MONOTONIC_CHECK_EN
        mono_err,
`endif
        wr_ready, busy, load_done, table_valid, restart_err, base, next__data
    );

    modport slave (
        input  load_start, wr_valid, wr_data, address,
        output
`ifdef ACT_LUT_MONOTONIC_CHECK_EN
        mono_err,
`endif
        wr_ready, busy, load_done, table_valid, restart_err, base, next__data
    );
endinterface

// File: rtl/act_lut_writer.sv
// act_lut_writer: run-time loadable 17-entry activation breakpoint table; define ACT_LUT_MONOTONIC_CHECK_EN to reject non-monotonic tables via mono_err
module act_lut_writer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             rst,
    act_lut_writer_if.slave bus
);
    localparam int N = (1 << ADDR_W) + 1;
    localparam logic [ADDR_W:0] LAST = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE  = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic        [ADDR_W:0]   r_idx;
    logic signed [DATA_W-1:0] r_mem [N];
    logic                     r_table_valid;
    logic                     w_accept;
    logic                     w_start;
    logic                     w_ok;
    logic        [ADDR_W:0]   w_addr;
    logic        [ADDR_W:0]   w_addr_n;

    // load_start is honoured in IDLE and LOAD but ignored in DONE
    assign w_start         = bus.load_start && r_state != DONE;
    assign bus.wr_ready    = r_state == LOAD && !bus.load_start;
    assign w_accept        = bus.wr_valid && bus.wr_ready;
    assign bus.busy        = r_state != IDLE;
    assign bus.load_done   = r_state == DONE;
    assign bus.table_valid = r_table_valid;
    assign bus.restart_err = r_state == LOAD && bus.load_start;
    // widened so address 15 reaches entry 16 instead of wrapping
    assign w_addr          = {1'b0, bus.address};
    assign w_addr_n        = w_addr + ONE;
    assign bus.base        = r_mem[w_addr];
    assign bus.next__data  = r_mem[w_addr_n];

`ifdef ACT_LUT_MONOTONIC_CHECK_EN
    logic                     r_viol;
    logic signed [DATA_W-1:0] r_prev;

    assign w_ok         = !r_viol;
    assign bus.mono_err = r_viol && r_state != LOAD;

    // sticky flag for any beat smaller than its predecessor in the current session
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_viol <= 1'b0;
            r_prev <= '0;
        end else if (w_start) begin
            r_viol <= 1'b0;
        end else if (w_accept) begin
            r_prev <= bus.wr_data;
            if (r_idx != '0 && bus.wr_data < r_prev)
                r_viol <= 1'b1;
        end
    end
`else
    assign w_ok = 1'b1;
`endif

    // session state register
    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // session sequencing: IDLE -> LOAD -> (17 beats) -> DONE -> IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.load_start) w_next = LOAD;
            LOAD:    if (w_accept && r_idx == LAST) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // register file writes, write index and table_valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_idx         <= '0;
            r_table_valid <= 1'b0;
            for (int i = 0; i < N; i++)
                r_mem[i] <= '0;
        end else begin
            if (w_start) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_mem[r_idx] <= bus.wr_data;
                r_idx        <= r_idx + ONE;
            end
            if (r_state == IDLE && bus.load_start)
                r_table_valid <= 1'b0;
            else if (r_state == DONE)
                r_table_valid <= w_ok;
        end
    end
endmodule

// File: tb/tb_act_lut_writer.sv
// tb_act_lut_writer: directed/randomized bench for act_lut_writer with a table-level reference model; covers ACT_LUT_MONOTONIC_CHECK_EN when defined
module tb_act_lut_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    act_lut_writer_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    act_lut_writer #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_pass = 0;
    int n_tot  = 0;
    int vals  [17];
    int exp_t [17];
    int widx;

    task automatic chk(input string tag, input logic signed [31:0] obs, input int exp_v);
        n_tot++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_table();
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            chk($sformatf("base[%0d]", a), bus.base, exp_t[a]);
            chk($sformatf("next[%0d]", a), bus.next__data, exp_t[a+1]);
        end
        tick();
    endtask

    task automatic start(input bit in_load);
        bus.load_start = 1'b1;
        if (!in_load) begin
            bus.wr_valid = 1'($urandom);
            bus.wr_data  = 8'($urandom);
        end
        @(negedge clk);
        chk("start_wr_ready", bus.wr_ready, 0);
        chk("start_restart_err", bus.restart_err, int'(in_load));
        chk("start_busy", bus.busy, int'(in_load));
        chk("start_load_done", bus.load_done, 0);
        tick();
        bus.load_start = 1'b0;
        widx = 0;
    endtask

    task automatic beats(input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            if (gap && k > 0) begin
                bus.wr_valid = 1'b0;
                bus.wr_data  = 8'($urandom);
                @(negedge clk);
                chk("gap_wr_ready", bus.wr_ready, 1);
                chk("gap_load_done", bus.load_done, 0);
                tick();
            end
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(vals[widx]);
            @(negedge clk);
            chk("beat_wr_ready", bus.wr_ready, 1);
            chk("beat_busy", bus.busy, 1);
            chk("beat_load_done", bus.load_done, 0);
            chk("beat_table_valid", bus.table_valid, 0);
            tick();
            exp_t[widx] = vals[widx];
            widx++;
        end
        bus.wr_valid = 1'b0;
    endtask

    task automatic done(input bit ok);
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("done_load_done", bus.load_done, 1);
        chk("done_wr_ready", bus.wr_ready, 0);
        chk("done_busy", bus.busy, 1);
        chk("done_table_valid", bus.table_valid, 0);
`ifdef ACT_LUT_MONOTONIC_CHECK_EN
        chk("done_mono_err", bus.mono_err, int'(!ok));
`endif
        tick();
        @(negedge clk);
        chk("post_load_done", bus.load_done, 0);
        chk("post_busy", bus.busy, 0);
        chk("post_table_valid", bus.table_valid, int'(ok));
    endtask

    task automatic random_ramp();
        vals[0] = -128 + int'($urandom_range(0, 15));
        for (int i = 1; i < 17; i++)
            vals[i] = vals[i-1] + int'($urandom_range(0, 14));
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.address    = '0;
        for (int i = 0; i < 17; i++) exp_t[i] = 0;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_load_done", bus.load_done, 0);
        chk("rst_table_valid", bus.table_valid, 0);
        chk("rst_restart_err", bus.restart_err, 0);
`ifdef ACT_LUT_MONOTONIC_CHECK_EN
        chk("rst_mono_err", bus.mono_err, 0);
`endif
        check_table();

        for (int i = 0; i < 17; i++) vals[i] = -64 + 8 * i;
        start(1'b0);
        beats(17, 1'b0);
        done(1'b1);
        bus.address = 4'd3;
        #1;
        chk("ramp_base3", bus.base, -40);
        chk("ramp_next3", bus.next__data, -32);
        bus.address = 4'd15;
        #1;
        chk("ramp_base15", bus.base, 56);
        chk("ramp_next15", bus.next__data, 64);
        tick();

        for (int i = 0; i < 17; i++) exp_t[i] = 0;
        start(1'b0);
        beats(17, 1'b1);
        done(1'b1);
        check_table();

        random_ramp();
        start(1'b0);
        beats(17, 1'b0);
        done(1'b1);
        check_table();

        random_ramp();
        start(1'b0);
        beats(5, 1'b0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'sd99;
        start(1'b1);
        bus.wr_valid = 1'b0;
        for (int i = 0; i < 17; i++) vals[i] = 7;
        beats(1, 1'b0);
        bus.address = 4'd4;
        @(negedge clk);
        chk("restart_mid_base4", bus.base, exp_t[4]);
        chk("restart_mid_next4", bus.next__data, exp_t[5]);
        chk("restart_mid_tv", bus.table_valid, 0);
        tick();
        beats(16, 1'b0);
        done(1'b1);
        check_table();

        random_ramp();
        start(1'b0);
        beats(10, 1'b0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_ready", bus.wr_ready, 0);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_table_valid", bus.table_valid, 0);
        chk("midrst_load_done", bus.load_done, 0);
        for (int i = 0; i < 17; i++) exp_t[i] = 0;
        check_table();

`ifdef ACT_LUT_MONOTONIC_CHECK_EN
        for (int i = 0; i < 17; i++) vals[i] = -64 + 8 * i;
        vals[9] = -100;
        start(1'b0);
        beats(17, 1'b0);
        done(1'b0);
        chk("mono_err_held", bus.mono_err, 1);
        check_table();
        vals[9] = 8;
        bus.wr_valid = 1'b0;
        start(1'b0);
        @(negedge clk);
        chk("mono_err_cleared", bus.mono_err, 0);
        tick();
        beats(17, 1'b0);
        done(1'b1);
        chk("mono_err_clean", bus.mono_err, 0);
        check_table();
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
